// File: rtl/switch_egress_scheduler.sv
// Egress frame scheduler: work-conserving round-robin over PORTS queues with frame lock
// and overlength policing. Define SCHED_PRIO_EN to add a prio_mask input for a priority class.
module switch_egress_scheduler #(
    parameter int WIDTH     = 128,
    parameter int PORTS     = 16,
    parameter int MAX_BEATS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PORTS*WIDTH-1:0]     in_data,
    input  logic [PORTS-1:0]           in_valid,
    input  logic [PORTS-1:0]           in_last,
    output logic [PORTS-1:0]           in_ready,
`ifdef SCHED_PRIO_EN
    input  logic [PORTS-1:0]           prio_mask,
`endif
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(PORTS)-1:0]   out_src,
    output logic                       busy,
    output logic                       err_overlength
);

    // state | meaning
    // IDLE  | no grant; arbitrate among valid queues (one bubble per frame)
    // BUSY  | granted queue drives egress until its last beat or forced release

    localparam int PTR_W = $clog2(PORTS);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    localparam logic [PTR_W:0]   PORTS_EXT = (PTR_W + 1)'(PORTS);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(PORTS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_FORCE = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_id;
    logic [CNT_W-1:0] beat_cnt;

    // Returns {found, index} of the first request after ptr, wrapping modulo PORTS.
    // Scanning from the far end lets the nearest candidate overwrite the result.
    function automatic logic [PTR_W:0] rr_search(input logic [PORTS-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0] sum;
        logic [PTR_W:0] result;
        result = '0;
        for (int off = PORTS; off >= 1; off--) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(off);
            if (sum >= PORTS_EXT) sum = sum - PORTS_EXT;
            if (req[sum[PTR_W-1:0]]) result = {1'b1, sum[PTR_W-1:0]};
        end
        return result;
    endfunction

    logic [PTR_W:0] pick;

    always_comb begin
`ifdef SCHED_PRIO_EN
        pick = rr_search(in_valid & prio_mask, rr_ptr);
        if (!pick[PTR_W]) pick = rr_search(in_valid, rr_ptr);
`else
        pick = rr_search(in_valid, rr_ptr);
`endif
    end

    logic [WIDTH-1:0] lane [PORTS];

    always_comb begin
        for (int i = 0; i < PORTS; i++) lane[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Egress is a straight combinational path from the granted queue head.
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        in_ready  = '0;
        if (state == BUSY) begin
            out_data           = lane[grant_id];
            out_valid          = in_valid[grant_id];
            out_last           = in_last[grant_id];
            in_ready[grant_id] = out_ready;
        end
    end

    logic xfer;
    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= LAST_PORT;
            grant_id       <= '0;
            beat_cnt       <= '0;
            out_src        <= '0;
            busy           <= 1'b0;
            err_overlength <= 1'b0;
        end else begin
            err_overlength <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick[PTR_W]) begin
                        state    <= BUSY;
                        grant_id <= pick[PTR_W-1:0];
                        out_src  <= pick[PTR_W-1:0];
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        if (beat_cnt != CNT_SAT) beat_cnt <= beat_cnt + CNT_W'(1);
                        // Overlength frames are cut here; the tail competes as a new frame.
                        if (out_last || beat_cnt == CNT_FORCE) begin
                            state          <= IDLE;
                            busy           <= 1'b0;
                            rr_ptr         <= grant_id;
                            err_overlength <= !out_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/switch_egress_scheduler.md
Name: switch_egress_scheduler

Overview:
- Per-output-port frame scheduler for the 16-port, 128-bit network switch.
- Shares one egress datapath among PORTS input queues using work-conserving round-robin arbitration.
- Once a queue is granted, the grant is held until that queue's end-of-frame beat has transferred.
- One instance sits between the ingress queues (depth 16) and each data_out port. It also polices overlength frames.

Parameters:
- WIDTH, 128, data beat width in bits.
- PORTS, 16, number of requesting input queues (≥2).
- MAX_BEATS, 64, maximum beats per frame before forced release.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  PORTS*WIDTH  head beat of each queue; queue i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  PORTS  queue i head beat valid.
- in_last  input  PORTS  queue i head beat is end of frame.
- in_ready  output  PORTS  pop strobe to queue i.
- out_data  output  WIDTH  egress beat.
- out_valid  output  1  egress beat valid.
- out_last  output  1  egress beat is end of frame.
- out_ready  input  1  egress sink accepts beat.
- out_src  output  $clog2(PORTS)  index of the granted queue.
- busy  output  1  frame in progress (state BUSY).
- err_overlength  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset state:
  - State IDLE; rr_ptr = PORTS-1, so port 0 has first priority.
  - grant_id = 0; beat_cnt = 0.
  - in_ready = 0, out_valid = 0, out_last = 0, out_data = 0, out_src = 0, busy = 0, err_overlength = 0.
- Reset asserted mid-frame: all of the above are re-applied the next cycle. The partially sent frame is abandoned; no further in_ready is issued.
- Transfer definition: a beat transfers when out_valid && out_ready.
- State IDLE:
  - Outputs are idle: out_valid = 0, in_ready = 0.
  - If any in_valid bit is set, search indices rr_ptr+1 … rr_ptr+PORTS (mod PORTS) and take the first set bit.
  - Register that index into grant_id and out_src, clear beat_cnt, and go to BUSY.
  - If no in_valid bit is set, stay in IDLE.
  - Arbitration costs exactly one bubble cycle per frame.
- State BUSY (combinational path from the granted queue):
  - out_data = in_data[grant_id], out_valid = in_valid[grant_id], out_last = in_last[grant_id].
  - in_ready[grant_id] = out_ready; all other in_ready bits = 0.
  - busy = 1. out_src holds grant_id.
  - in_valid dropping mid-frame: out_valid follows it low and the grant is held (no timeout on gaps).
  - Each transfer increments beat_cnt, saturating at MAX_BEATS.
  - Transfer with out_last = 1: rr_ptr ← grant_id, go to IDLE.
  - Transfer while beat_cnt == MAX_BEATS-1 and out_last = 0: forced release. rr_ptr ← grant_id, go to IDLE, err_overlength = 1 for the following cycle. The remainder of the frame is re-arbitrated as a new frame.
- Fairness: after serving port k, port k has lowest priority in the next arbitration. A continuously requesting port waits at most PORTS-1 frames.
- Single requester: served back-to-back with one bubble between frames.
- out_ready = 0 holds all state. out_data is stable while out_valid && !out_ready.
- Widths:
  - beat_cnt is $clog2(MAX_BEATS+1) bits.
  - Pointer arithmetic is modulo PORTS, correct for non-power-of-two PORTS.

Optional Feature:
- Macro SCHED_PRIO_EN.
- When defined:
  - Adds input prio_mask [PORTS].
  - IDLE first searches (in_valid & prio_mask) in round-robin order from rr_ptr+1. Only if that set is empty does it search in_valid.
  - rr_ptr is shared between the two classes.
  - Frame lock, watchdog and handshake are unchanged.
- When undefined:
  - prio_mask port does not exist.
  - Arbitration is pure round-robin as above.

Test Plan:
- Reset, then in_valid = 16'h0010, a 1-beat frame on port 4 with in_data[4] = 128'h23456789ABCDEF0AABBCC11223344566 and out_ready = 1 → one IDLE cycle, then out_valid = 1, out_src = 4, out_data = that value, out_last = 1, in_ready = 16'h0010 for one cycle, then back to IDLE.
- Ports 0, 4 and 15 continuously valid with 2-beat frames, out_ready = 1 → grant order 0, 4, 15, 0, 4, 15; each grant lasts 2 beats plus 1 bubble.
- Port 0 grant with 3-beat frame, out_ready low on beat 2 for 3 cycles → out_data holds beat 2, in_ready[0] = 0 during the stall, beat_cnt unchanged; frame completes with 3 transfers total.
- Port 2 streams 64 beats with in_last = 0 (MAX_BEATS = 64) → after the 64th transfer, return to IDLE and err_overlength pulses once. With port 3 also valid, the next grant goes to port 3.
- Reset asserted on beat 2 of a 5-beat frame from port 7 → the next cycle shows in_ready = 0, out_valid = 0, busy = 0. With ports 0 and 7 valid afterwards, the first grant goes to port 0.
- SCHED_PRIO_EN defined, prio_mask = 16'h8000, ports 1 and 15 valid → port 15 is granted every frame while its valid is held. Port 1 is granted only once port 15 deasserts.
